// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 100 MHz system clock at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and occupancy count.
// Flags come from the registered count, so a pop never frees a slot for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames leave back-to-back while entries remain.
// state     | meaning
// ST_IDLE   | line high, waiting for a FIFO entry
// ST_START  | start bit (0)
// ST_DATA   | payload, LSB first
// ST_PARITY | parity bit (only when PARITY != PAR_NONE)
// ST_STOP   | stop bit(s), line high
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  state_t                 state;
  logic [TW-1:0]          bit_timer;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   fifo_q;
  logic                   parity_bit;
  logic                   tick_end;
  logic                   frame_end;
  logic                   pop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_q),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign wr_ready  = !fifo_full;
  assign overflow  = wr_valid && fifo_full && !rst;
  assign busy      = (state != ST_IDLE);
  assign tick_end  = (bit_timer == TICK_LAST);
  assign frame_end = (state == ST_STOP) && tick_end && (bit_idx == STOP_LAST);
  // Popping at the end of the last stop bit chains frames with no idle gap.
  assign pop       = !fifo_empty && ((state == ST_IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_timer  <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      if (state == ST_IDLE || tick_end) bit_timer <= '0;
      else                              bit_timer <= bit_timer + 1'b1;

      if (pop) begin
        state      <= ST_START;
        tx         <= 1'b0;
        shreg      <= fifo_q;
        parity_bit <= (^fifo_q) ^ (PARITY == PAR_ODD);
      end else if (tick_end) begin
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
          ST_DATA: begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          ST_PARITY: begin
            state   <= ST_STOP;
            tx      <= 1'b1;
            bit_idx <= '0;
          end
          ST_STOP: begin
            if (bit_idx == STOP_LAST) state   <= ST_IDLE;
            else                      bit_idx <= bit_idx + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four configurations at 4 clocks per bit, observed through a shared select mux.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wv;
  logic [7:0] wd;
  int         sel;
  int         n_cmp;
  int         n_err;

  logic       wv_v   [4];
  logic       rdy_v  [4];
  logic       tx_v   [4];
  logic       busy_v [4];
  logic [2:0] cnt_v  [4];
  logic       emp_v  [4];
  logic       full_v [4];
  logic       ovf_v  [4];

  logic       tx_m, busy_m, rdy_m, emp_m, full_m, ovf_m;
  logic [2:0] cnt_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) wv_v[i] = wv && (sel == i);
    tx_m   = tx_v[sel];
    busy_m = busy_v[sel];
    rdy_m  = rdy_v[sel];
    emp_m  = emp_v[sel];
    full_m = full_v[sel];
    ovf_m  = ovf_v[sel];
    cnt_m  = cnt_v[sel];
  end

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2 -- all with a 4-entry FIFO
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .wr_data(wd), .wr_valid(wv_v[0]), .wr_ready(rdy_v[0]), .tx(tx_v[0]),
    .busy(busy_v[0]), .fifo_count(cnt_v[0]), .fifo_empty(emp_v[0]), .fifo_full(full_v[0]), .overflow(ovf_v[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .wr_data(wd), .wr_valid(wv_v[1]), .wr_ready(rdy_v[1]), .tx(tx_v[1]),
    .busy(busy_v[1]), .fifo_count(cnt_v[1]), .fifo_empty(emp_v[1]), .fifo_full(full_v[1]), .overflow(ovf_v[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst(rst), .wr_data(wd), .wr_valid(wv_v[2]), .wr_ready(rdy_v[2]), .tx(tx_v[2]),
    .busy(busy_v[2]), .fifo_count(cnt_v[2]), .fifo_empty(emp_v[2]), .fifo_full(full_v[2]), .overflow(ovf_v[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_5n2 (
    .clk(clk), .rst(rst), .wr_data(wd[4:0]), .wr_valid(wv_v[3]), .wr_ready(rdy_v[3]), .tx(tx_v[3]),
    .busy(busy_v[3]), .fifo_count(cnt_v[3]), .fifo_empty(emp_v[3]), .fifo_full(full_v[3]), .overflow(ovf_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bits[k] is the k-th bit on the line; each bit lasts 4 cycles. Samples offsets first..last-1.
  task automatic line_check(input string tag, input logic [63:0] bits, input int first, input int last);
    for (int i = first; i < last; i++) begin
      check(tag, tx_m, bits[i/4]);
      check({tag, "_busy"}, busy_m, 1);
      @(negedge clk);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wd = d;
    wv = 1'b1;
    @(negedge clk);
    wv = 1'b0;
  endtask

  logic [63:0] stream;

  initial begin
    n_cmp = 0;
    n_err = 0;
    sel   = 0;
    wv    = 1'b0;
    wd    = '0;
    rst   = 1'b1;

    // reset, with a write presented that must be ignored
    @(negedge clk);
    wv = 1'b1;
    wd = 8'h99;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("rst_tx", tx_m, 1);
      check("rst_busy", busy_m, 0);
      check("rst_count", cnt_m, 0);
      check("rst_empty", emp_m, 1);
      check("rst_full", full_m, 0);
      check("rst_ready", rdy_m, 1);
      check("rst_ovf", ovf_m, 0);
    end
    sel = 0;
    wv  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_count", cnt_m, 0);
    check("post_rst_tx", tx_m, 1);

    // 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1
    push(8'hA5);
    check("a5_count", cnt_m, 1);
    check("a5_tx_pre", tx_m, 1);
    check("a5_busy_pre", busy_m, 0);
    @(negedge clk);
    line_check("a5_line", 64'h34A, 0, 40);
    check("a5_busy_end", busy_m, 0);
    check("a5_tx_end", tx_m, 1);
    check("a5_empty", emp_m, 1);

    // 8E1 and 8O1 with 0x07: parity 1 then 0, 44-cycle frames
    sel = 1;
    push(8'h07);
    @(negedge clk);
    line_check("even_line", 64'h60E, 0, 44);
    check("even_busy_end", busy_m, 0);
    sel = 2;
    push(8'h07);
    @(negedge clk);
    line_check("odd_line", 64'h40E, 0, 44);
    check("odd_busy_end", busy_m, 0);

    // 5N2 with 0x1F: 0,1,1,1,1,1,1,1 over 32 cycles
    sel = 3;
    push(8'h1F);
    @(negedge clk);
    line_check("5n2_line", 64'hFE, 0, 32);
    check("5n2_busy_end", busy_m, 0);
    check("5n2_tx_end", tx_m, 1);

    // burst of 6 writes into the 4-deep FIFO while the first frame starts
    sel = 0;
    stream = {14'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0,
              1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
    wd = 8'h11; wv = 1'b1;
    @(negedge clk);
    check("burst_cnt1", cnt_m, 1);
    check("burst_ovf1", ovf_m, 0);
    wd = 8'h22;
    @(negedge clk);
    check("burst_cnt2", cnt_m, 1);
    check("burst_tx2", tx_m, 0);
    check("burst_ovf2", ovf_m, 0);
    wd = 8'h33;
    @(negedge clk);
    check("burst_cnt3", cnt_m, 2);
    check("burst_tx3", tx_m, 0);
    wd = 8'h44;
    @(negedge clk);
    check("burst_cnt4", cnt_m, 3);
    check("burst_ready4", rdy_m, 1);
    check("burst_ovf4", ovf_m, 0);
    wd = 8'h55;
    @(negedge clk);
    wd = 8'h66;
    #1;
    check("burst_cnt5", cnt_m, 4);
    check("burst_full5", full_m, 1);
    check("burst_ready5", rdy_m, 0);
    check("burst_ovf5", ovf_m, 1);
    check("burst_tx5", tx_m, 0);
    @(negedge clk);
    wv = 1'b0;
    #1;
    check("burst_cnt6", cnt_m, 4);
    check("burst_ovf6", ovf_m, 0);
    line_check("burst_line", stream, 4, 200);
    check("burst_busy_end", busy_m, 0);
    check("burst_empty_end", emp_m, 1);
    check("burst_tx_end", tx_m, 1);

    // push and pop on the same edge at count 2
    stream = {24'b0, 1'b1, 8'hC4, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 8'hC1, 1'b0};
    wd = 8'hC1; wv = 1'b1;
    @(negedge clk);
    wd = 8'hC2;
    @(negedge clk);
    check("pp_tx0", tx_m, 0);
    wd = 8'hC3;
    @(negedge clk);
    wv = 1'b0;
    check("pp_cnt_before", cnt_m, 2);
    line_check("pp_line_a", stream, 1, 39);
    check("pp_tx39", tx_m, 1);
    wd = 8'hC4; wv = 1'b1;
    @(negedge clk);
    wv = 1'b0;
    check("pp_cnt_same", cnt_m, 2);
    line_check("pp_line_b", stream, 40, 160);
    check("pp_busy_end", busy_m, 0);
    check("pp_empty_end", emp_m, 1);

    // reset mid-DATA with three bytes queued
    wd = 8'h00; wv = 1'b1;
    @(negedge clk);
    wd = 8'hD2;
    @(negedge clk);
    wd = 8'hD3;
    @(negedge clk);
    wd = 8'hD4;
    @(negedge clk);
    wv = 1'b0;
    check("mrst_cnt", cnt_m, 3);
    repeat (8) @(negedge clk);
    check("mrst_tx_data", tx_m, 0);
    check("mrst_busy_data", busy_m, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_tx", tx_m, 1);
    check("mrst_busy", busy_m, 0);
    check("mrst_count", cnt_m, 0);
    check("mrst_empty", emp_m, 1);
    check("mrst_ready", rdy_m, 1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("mrst_quiet_tx", tx_m, 1);
      check("mrst_quiet_busy", busy_m, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning FIFO entries; power of two, >= 2.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port wr_data  input  DATA_BITS  byte to enqueue.
REQ-009 SHALL have port wr_valid  input  1  wr_data is valid.
REQ-010 SHALL have port wr_ready  output  1  FIFO can accept; equals !fifo_full.
REQ-011 SHALL have port tx  output  1  registered serial line, idle high.
REQ-012 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-014 SHALL have ports fifo_empty and fifo_full  output  1 each  FIFO status flags.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse when wr_valid is high while fifo_full is high.

Function
REQ-016 A write SHALL be accepted on a rising edge where wr_valid && wr_ready; rejected data is dropped, never queued.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY==0.
REQ-018 In IDLE with fifo_empty low, the FSM SHALL pop one entry and enter START on the same edge; tx goes 0 on that edge.
REQ-019 Latency from write acceptance into an empty FIFO with an idle FSM SHALL be exactly 1 cycle to tx falling.
REQ-020 Each bit SHALL be held exactly CLKS_PER_BIT cycles, counted by a bit-timer that runs 0..CLKS_PER_BIT-1 and wraps.
REQ-021 DATA SHALL shift out LSB first, DATA_BITS bits.
REQ-022 The parity bit SHALL be the XOR of the data bits (even) or its inverse (odd).
REQ-023 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-025 At the end of STOP with the FIFO non-empty, the FSM SHALL pop and enter START directly, with zero idle cycles between frames.
REQ-026 A simultaneous push and pop SHALL leave fifo_count unchanged, and the FIFO SHALL retain both data.
REQ-027 At full, a pop SHALL NOT enable a write in the same cycle, because wr_ready is derived from the registered full state.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL reach FIFO_DEPTH exactly when full.
REQ-029 The frame byte SHALL be latched at pop; FIFO writes during a frame SHALL NOT alter the frame in flight.

Reset
REQ-030 While rst is high: tx=1, busy=0, FSM=IDLE, bit-timer=0, FIFO flushed (fifo_count=0, fifo_empty=1, fifo_full=0, wr_ready=1), overflow=0.
REQ-031 rst asserted mid-frame SHALL abort the frame at the next edge (tx=1), with no partial resend after release.
REQ-032 A write presented while rst is high SHALL be ignored.

Structure
REQ-033 Shared package uart_pkg SHALL hold the state enum, the parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD), and the default CLKS_PER_BIT.
REQ-034 The FIFO SHALL be one sub-module, sync_fifo (parametrised WIDTH and DEPTH, with count/full/empty); the serialiser FSM resides in uart_tx_fifo.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-035 Bench SHALL cover: 8N1, write 0xA5 to idle block -> tx falls 1 cycle later; line reads 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy high for 40 cycles.
REQ-036 Bench SHALL cover: PARITY=1 with 0x07, then PARITY=2 with 0x07 -> parity bit 1 (even), then 0 (odd); frame length 44 cycles.
REQ-037 Bench SHALL cover: FIFO_DEPTH=4, burst of 6 writes while busy -> wr_ready drops at count 4, overflow pulses on each rejected cycle, first 5 bytes (1 in flight + 4 queued) transmitted in order with no gaps.
REQ-038 Bench SHALL cover: DATA_BITS=5, STOP_BITS=2, write 0x1F -> frame 0,1,1,1,1,1,1,1, total 32 cycles.
REQ-039 Bench SHALL cover: rst pulsed 1 cycle in mid-DATA with 3 bytes queued -> tx=1 next edge, fifo_count=0, no further frames.
REQ-040 Bench SHALL cover: push and pop on the same edge at count 2 -> count stays 2, and output order matches input order.
